// File: rtl/count_share_controller_pkg.sv
// ---------------------------------------------------------------------------
// count_share_controller_pkg
//   Shared definitions for the count-share controller slice: the default
//   counter width, the controller FSM state encoding and a small grant helper.
//   Ports: none (package).
// ---------------------------------------------------------------------------
package count_share_controller_pkg;

  localparam int DEF_SIZE = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Converts a requester index into the one-hot {gnt1,gnt0} pattern.
  function automatic logic [1:0] onehot_grant(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/count_share_controller_if.sv
// ---------------------------------------------------------------------------
// count_share_controller_if
//   Bundles the requester handshake, the datapath control/return signals and
//   the status outputs of the count-share controller.
//   Signals:
//     req0, req1        requester levels
//     limit0, limit1    requester terminal counts (SIZE bits)
//     count_dp          count returned by the external datapath (SIZE bits)
//     clr_dp, en_dp     datapath synchronous clear / count enable
//     gnt               one-hot grant {gnt1,gnt0}
//     done, done_id     completion pulse and finished requester index
//     busy              controller not idle
//   Modports:
//     master  requester/datapath side (drives requests, limits, count)
//     slave   controller side
// ---------------------------------------------------------------------------
interface count_share_controller_if
  import count_share_controller_pkg::*;
#(
  parameter int SIZE = DEF_SIZE
) ();

  logic            req0;
  logic            req1;
  logic [SIZE-1:0] limit0;
  logic [SIZE-1:0] limit1;
  logic [SIZE-1:0] count_dp;
  logic            clr_dp;
  logic            en_dp;
  logic [1:0]      gnt;
  logic            done;
  logic            done_id;
  logic            busy;

  modport master (
    output req0, req1, limit0, limit1, count_dp,
    input  clr_dp, en_dp, gnt, done, done_id, busy
  );

  modport slave (
    input  req0, req1, limit0, limit1, count_dp,
    output clr_dp, en_dp, gnt, done, done_id, busy
  );

endinterface

// File: rtl/count_share_controller_rr_arbiter_2.sv
// ---------------------------------------------------------------------------
// rr_arbiter_2
//   Purely combinational two-way round-robin arbiter. The caller owns the
//   'last' register and updates it with 'winner' when it takes the grant.
//   Ports:
//     req     in  2  request vector {req1,req0}
//     last    in  1  index granted most recently
//     winner  out 1  index that wins this cycle (meaningful when any=1)
//     any     out 1  at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       any
);

  // A lone request always wins; on a tie the index that did not win last
  // time gets the grant.
  always_comb begin
    any    = |req;
    winner = 1'b0;
    if (req == 2'b11) begin
      winner = ~last;
    end else if (req[1]) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/count_share_controller.sv
// ---------------------------------------------------------------------------
// count_share_controller
//   Time-shares one external binary-counter datapath between two requesters.
//   A request is granted round-robin, the winner's terminal count is latched,
//   the datapath is cleared for one cycle and then enabled until its count
//   reaches the latched limit, after which a one-cycle done pulse is issued.
//   Ports:
//     clk   in  1  clock, all state changes on posedge
//     rst   in  1  synchronous active-high reset
//     bus   slave modport of count_share_controller_if (requests, limits,
//           count_dp in; clr_dp, en_dp, gnt, done, done_id, busy out)
// ---------------------------------------------------------------------------
module count_share_controller
  import count_share_controller_pkg::*;
#(
  parameter int SIZE = DEF_SIZE
) (
  input logic                     clk,
  input logic                     rst,
  count_share_controller_if.slave bus
);

  state_t          state;
  state_t          next_state;
  logic [SIZE-1:0] limit_q;
  logic [1:0]      gnt_q;
  logic            owner;
  logic            last;
  logic            winner;
  logic            any;
  logic            owner_req;
  logic            at_limit;

  rr_arbiter_2 u_arb (
    .req    ({bus.req1, bus.req0}),
    .last   (last),
    .winner (winner),
    .any    (any)
  );

  // Only the current owner's request matters once granted; the other
  // requester waits for the next IDLE.
  assign owner_req = owner ? bus.req1 : bus.req0;
  assign at_limit  = (bus.count_dp == limit_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // An owner dropping its request in CLEAR or RUN abandons the job, and
  // that takes priority over reaching the limit.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (any) next_state = CLEAR;
      CLEAR: next_state = owner_req ? RUN : IDLE;
      RUN: begin
        if (!owner_req) begin
          next_state = IDLE;
        end else if (at_limit) begin
          next_state = DONE;
        end
      end
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Grant-time registers. 'last' resets to 1 so requester 0 wins the first
  // tie after reset. The grant is cleared whenever the FSM heads to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q   <= 2'b00;
      limit_q <= '0;
      owner   <= 1'b0;
      last    <= 1'b1;
    end else if (state == IDLE && any) begin
      gnt_q   <= onehot_grant(winner);
      limit_q <= winner ? bus.limit1 : bus.limit0;
      owner   <= winner;
      last    <= winner;
    end else if (next_state == IDLE) begin
      gnt_q <= 2'b00;
    end
  end

  // Everything except gnt decodes from the state; en_dp also looks at the
  // returned count so the datapath stops exactly on the limit.
  always_comb begin
    bus.clr_dp  = 1'b0;
    bus.en_dp   = 1'b0;
    bus.done    = 1'b0;
    bus.done_id = 1'b0;
    bus.busy    = (state != IDLE);
    bus.gnt     = gnt_q;
    unique case (state)
      CLEAR: bus.clr_dp = 1'b1;
      RUN:   bus.en_dp  = ~at_limit;
      DONE: begin
        bus.done    = 1'b1;
        bus.done_id = owner;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_count_share_controller.sv
// ---------------------------------------------------------------------------
// tb_count_share_controller
//   Self-checking bench for count_share_controller. Includes a behavioural
//   counter datapath (sync clear over enable) driven by the DUT.
// ---------------------------------------------------------------------------
module tb_count_share_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] dp_count = 4'd0;
  int         tests = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  count_share_controller_if #(.SIZE(4)) bus ();

  count_share_controller #(.SIZE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External counter datapath; deliberately not reset by rst.
  always_ff @(posedge clk) begin
    if (bus.clr_dp) begin
      dp_count <= 4'd0;
    end else if (bus.en_dp) begin
      dp_count <= dp_count + 4'd1;
    end
  end
  assign bus.count_dp = dp_count;

  typedef struct {
    logic       r;
    logic       r0;
    logic       r1;
    logic [3:0] l0;
    logic [3:0] l1;
    logic [1:0] gnt;
    logic       busy;
    logic       clr;
    logic       en;
    logic       done;
    logic       did;
  } vec_t;

  vec_t vecs[12];

  // Reference model state: a job is described by who owns it, its limit and
  // how many cycles have passed since the grant (1 = clear cycle).
  bit m_active;
  int m_owner;
  int m_limit;
  int m_age;
  int m_last;

  task automatic applyStimulus(input logic r, input logic r0, input logic r1,
                               input logic [3:0] l0, input logic [3:0] l1);
    rst        = r;
    bus.req0   = r0;
    bus.req1   = r1;
    bus.limit0 = l0;
    bus.limit1 = l1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_active = 1'b0;
    m_owner  = 0;
    m_limit  = 0;
    m_age    = 0;
    m_last   = 1;
  endtask

  // Advances the model by one clock using the inputs present before the edge.
  task automatic modelStep(input logic r, input logic r0, input logic r1,
                           input logic [3:0] l0, input logic [3:0] l1);
    int w;
    if (r) begin
      modelReset();
    end else if (!m_active) begin
      if (r0 || r1) begin
        if (r0 && r1) w = 1 - m_last;
        else          w = r1 ? 1 : 0;
        m_active = 1'b1;
        m_owner  = w;
        m_limit  = (w == 1) ? int'(l1) : int'(l0);
        m_age    = 1;
        m_last   = w;
      end
    end else if (m_age == m_limit + 3) begin
      m_active = 1'b0;
    end else if (!((m_owner == 1) ? r1 : r0)) begin
      m_active = 1'b0;
    end else begin
      m_age++;
    end
  endtask

  task automatic modelCompare();
    int e_done;
    e_done = (m_active && m_age == m_limit + 3) ? 1 : 0;
    checkOutput("rnd_gnt",  int'(bus.gnt),  m_active ? (1 << m_owner) : 0);
    checkOutput("rnd_busy", int'(bus.busy), m_active ? 1 : 0);
    checkOutput("rnd_clr",  int'(bus.clr_dp), (m_active && m_age == 1) ? 1 : 0);
    checkOutput("rnd_en",   int'(bus.en_dp),
                (m_active && m_age >= 2 && m_age <= m_limit + 1) ? 1 : 0);
    checkOutput("rnd_done", int'(bus.done), e_done);
    checkOutput("rnd_done_id", int'(bus.done_id), (e_done == 1) ? m_owner : 0);
  endtask

  initial begin
    logic [1:0] prev_gnt;
    int         grants[4];
    int         ng;
    int         en_cnt;
    int         done_at;
    int         done_count;
    int         done_seen;
    logic       r, r0, r1;
    logic [3:0] l0, l1;

    rst        = 1'b1;
    bus.req0   = 1'b0;
    bus.req1   = 1'b0;
    bus.limit0 = 4'd0;
    bus.limit1 = 4'd0;
    @(negedge clk);

    // Single request with limit 3, then a lone req1 with limit 0.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 4'd3, 4'd0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 4'd3, 4'd0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 4'd3, 4'd0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 4'd3, 4'd0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 4'd3, 4'd0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 4'd3, 4'd0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 4'd3, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 4'd9, 4'd0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 4'd9, 4'd0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 4'd9, 4'd0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 4'd9, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].r, vecs[i].r0, vecs[i].r1, vecs[i].l0, vecs[i].l1);
      checkOutput($sformatf("vec%0d_gnt", i),  int'(bus.gnt),     int'(vecs[i].gnt));
      checkOutput($sformatf("vec%0d_busy", i), int'(bus.busy),    int'(vecs[i].busy));
      checkOutput($sformatf("vec%0d_clr", i),  int'(bus.clr_dp),  int'(vecs[i].clr));
      checkOutput($sformatf("vec%0d_en", i),   int'(bus.en_dp),   int'(vecs[i].en));
      checkOutput($sformatf("vec%0d_done", i), int'(bus.done),    int'(vecs[i].done));
      checkOutput($sformatf("vec%0d_did", i),  int'(bus.done_id), int'(vecs[i].did));
    end

    // Both requests held from reset: grants must alternate 0,1,0,1.
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd1, 4'd2);
    prev_gnt = 2'b00;
    ng = 0;
    for (int i = 0; i < 4; i++) grants[i] = -1;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 4'd1, 4'd2);
      if (prev_gnt == 2'b00 && bus.gnt != 2'b00) begin
        grants[ng] = (bus.gnt == 2'b10) ? 1 : 0;
        ng++;
      end
      prev_gnt = bus.gnt;
    end
    checkOutput("alt_grants_seen", ng, 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("alt_grant%0d", i), grants[i], i % 2);
    end

    // Limit 15: en_dp high exactly 15 cycles, done at t+18, no wrap.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    en_cnt = 0;
    done_at = 0;
    done_count = -1;
    for (int k = 1; k <= 30 && done_at == 0; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 4'd15, 4'd0);
      if (bus.en_dp) en_cnt++;
      if (bus.done) begin
        done_at = k;
        done_count = int'(bus.count_dp);
      end
    end
    checkOutput("max_done_cycle", done_at, 18);
    checkOutput("max_en_cycles", en_cnt, 15);
    checkOutput("max_count_at_done", done_count, 15);
    checkOutput("max_done_id", int'(bus.done_id), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

    // Owner drops req0 in its 2nd RUN cycle; pending req1 then wins.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd5, 4'd2);
    checkOutput("abn_gnt_clear", int'(bus.gnt), 1);
    checkOutput("abn_clr", int'(bus.clr_dp), 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd5, 4'd2);
    checkOutput("abn_run1_en", int'(bus.en_dp), 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd5, 4'd2);
    checkOutput("abn_run2_en", int'(bus.en_dp), 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd5, 4'd2);
    checkOutput("abn_gnt_idle", int'(bus.gnt), 0);
    checkOutput("abn_busy", int'(bus.busy), 0);
    checkOutput("abn_done", int'(bus.done), 0);
    checkOutput("abn_en", int'(bus.en_dp), 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd5, 4'd2);
    checkOutput("abn_req1_gnt", int'(bus.gnt), 2);
    checkOutput("abn_req1_clr", int'(bus.clr_dp), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd5, 4'd2);

    // Reset in RUN, then the first tie after reset goes to req0.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    done_seen = 0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 4'd10, 4'd3);
      if (bus.done) done_seen = 1;
    end
    checkOutput("rst_pre_en", int'(bus.en_dp), 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd10, 4'd3);
    checkOutput("rst_gnt", int'(bus.gnt), 0);
    checkOutput("rst_busy", int'(bus.busy), 0);
    checkOutput("rst_en", int'(bus.en_dp), 0);
    checkOutput("rst_done", int'(bus.done) | done_seen, 0);
    checkOutput("rst_clr", int'(bus.clr_dp), 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd10, 4'd3);
    checkOutput("rst_tie_gnt", int'(bus.gnt), 1);

    // Randomized traffic against the reference model.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    modelReset();
    r0 = 1'b0;
    r1 = 1'b0;
    for (int c = 0; c < 800; c++) begin
      r  = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 9) == 0) r0 = ~r0;
      if ($urandom_range(0, 9) == 0) r1 = ~r1;
      l0 = 4'($urandom_range(0, 15));
      l1 = 4'($urandom_range(0, 15));
      modelStep(r, r0, r1, l0, l1);
      applyStimulus(r, r0, r1, l0, l1);
      modelCompare();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
